// File: rtl/braille_pkg.sv
// braille_pkg
//   Shared definitions for the braille trainer round controller:
//   letter codes, the 6-dot braille pattern of each letter code,
//   the round FSM state encoding and the LFSR feedback taps.
//   Dots are packed bit0=dot1 .. bit5=dot6, 1 = raised.
package braille_pkg;

    // Letter codes as understood by the seg7 letter decoder.
    // Codes 12 and 13 both display P.
    localparam logic [3:0] LTR_A  = 4'd0;
    localparam logic [3:0] LTR_B  = 4'd1;
    localparam logic [3:0] LTR_C  = 4'd2;
    localparam logic [3:0] LTR_D  = 4'd3;
    localparam logic [3:0] LTR_E  = 4'd4;
    localparam logic [3:0] LTR_F  = 4'd5;
    localparam logic [3:0] LTR_G  = 4'd6;
    localparam logic [3:0] LTR_H  = 4'd7;
    localparam logic [3:0] LTR_I  = 4'd8;
    localparam logic [3:0] LTR_J  = 4'd9;
    localparam logic [3:0] LTR_L  = 4'd10;
    localparam logic [3:0] LTR_O  = 4'd11;
    localparam logic [3:0] LTR_P  = 4'd12;
    localparam logic [3:0] LTR_P2 = 4'd13;
    localparam logic [3:0] LTR_U  = 4'd14;
    localparam logic [3:0] LTR_Y  = 4'd15;

    // Value of the previous-letter register out of reset; no letter
    // has been shown yet.
    localparam logic [3:0] PREV_RST = 4'hF;

    // Fibonacci taps 16,14,13,11 expressed as a mask over q[15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

    // Braille dot pattern expected for each letter code.
    function automatic logic [5:0] braille_pattern(input logic [3:0] code);
        logic [5:0] p;
        case (code)
            LTR_A:   p = 6'b000001;
            LTR_B:   p = 6'b000011;
            LTR_C:   p = 6'b001001;
            LTR_D:   p = 6'b011001;
            LTR_E:   p = 6'b010001;
            LTR_F:   p = 6'b001011;
            LTR_G:   p = 6'b011011;
            LTR_H:   p = 6'b010011;
            LTR_I:   p = 6'b001010;
            LTR_J:   p = 6'b011010;
            LTR_L:   p = 6'b000111;
            LTR_O:   p = 6'b010101;
            LTR_P:   p = 6'b001111;
            LTR_P2:  p = 6'b001111;
            LTR_U:   p = 6'b100101;
            default: p = 6'b111101; // LTR_Y
        endcase
        return p;
    endfunction

endpackage

// File: rtl/braille_round_ctrl_if.sv
// braille_round_if
//   Bundles the round controller's player-side inputs and display/status
//   outputs.
//   slave  : the controller (consumes start/submit/dots_in/score_clr,
//            drives letter_out/disp_en/correct/wrong/timeout/busy/score)
//   master : the front end / environment driving the controller
interface braille_round_if #(
    parameter int SCORE_W = 8
);
    logic               start;
    logic               submit;
    logic [5:0]         dots_in;
    logic               score_clr;
    logic [3:0]         letter_out;
    logic               disp_en;
    logic               correct;
    logic               wrong;
    logic               timeout;
    logic               busy;
    logic [SCORE_W-1:0] score;

    modport slave (
        input  start, submit, dots_in, score_clr,
        output letter_out, disp_en, correct, wrong, timeout, busy, score
    );

    modport master (
        output start, submit, dots_in, score_clr,
        input  letter_out, disp_en, correct, wrong, timeout, busy, score
    );
endinterface

// File: rtl/lfsr16.sv
// lfsr16
//   Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting every
//   cycle. Starting from a non-zero SEED it never reaches the all-zero
//   lock-up state.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, loads SEED
//   q     : current register value
module lfsr16
    import braille_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= SEED;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/braille_round_ctrl.sv
// braille_round_ctrl
//   Game-round controller for the braille trainer. On start it picks a
//   pseudo-random letter (never the same as the previous one), shows it
//   via letter_out/disp_en, waits for the player's 6-dot entry or a
//   timeout, grades the entry and keeps a saturating score.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus.start      : pulse, begin a round (from IDLE or RESULT)
//   bus.submit     : pulse, player entry complete (SHOW only)
//   bus.dots_in    : braille dots, bit0=dot1 .. bit5=dot6
//   bus.score_clr  : synchronous score clear, wins over an increment
//   bus.letter_out : letter code to the seg7 decoder
//   bus.disp_en    : display enable (low only in IDLE)
//   bus.correct/wrong/timeout : result of the last round, levels
//   bus.busy       : high in SHOW and CHECK
//   bus.score      : correct-round count, saturating
module braille_round_ctrl
    import braille_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 250000000,
    parameter int          SCORE_W        = 8,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst_n,
    braille_round_if.slave  bus
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

    logic [15:0] lfsr_q;
    logic        unused_lfsr_hi;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr_q)
    );

    // Only the low nibble picks the letter.
    assign unused_lfsr_hi = ^lfsr_q[15:4];

    state_e               state_q,   state_d;
    logic [3:0]           letter_q,  letter_d;
    logic [3:0]           prev_q,    prev_d;
    logic [TIMER_W-1:0]   timer_q,   timer_d;
    logic [5:0]           dots_q,    dots_d;
    logic                 correct_q, correct_d;
    logic                 wrong_q,   wrong_d;
    logic                 timeout_q, timeout_d;
    logic [SCORE_W-1:0]   score_q,   score_d;

    logic [3:0] pick;

    // Bump the candidate by one if it would repeat the last letter, so
    // the player never sees the same letter twice in a row.
    always_comb begin
        pick = (lfsr_q[3:0] == prev_q) ? (lfsr_q[3:0] + 4'd1) : lfsr_q[3:0];
    end

    always_comb begin
        state_d   = state_q;
        letter_d  = letter_q;
        prev_d    = prev_q;
        timer_d   = timer_q;
        dots_d    = dots_q;
        correct_d = correct_q;
        wrong_d   = wrong_q;
        timeout_d = timeout_q;
        score_d   = score_q;

        case (state_q)
            ST_IDLE, ST_RESULT: begin
                if (bus.start) begin
                    state_d   = ST_SHOW;
                    letter_d  = pick;
                    prev_d    = pick;
                    timer_d   = '0;
                    correct_d = 1'b0;
                    wrong_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_SHOW: begin
                timer_d = timer_q + TIMER_W'(1);
                // A submit in the timeout cycle still gets graded.
                if (bus.submit) begin
                    state_d = ST_CHECK;
                    dots_d  = bus.dots_in;
                end else if (timer_q == TIMER_LAST) begin
                    state_d   = ST_RESULT;
                    timeout_d = 1'b1;
                end
            end
            ST_CHECK: begin
                state_d = ST_RESULT;
                if (dots_q == braille_pattern(letter_q)) begin
                    correct_d = 1'b1;
                    if (score_q != SCORE_MAX) score_d = score_q + SCORE_W'(1);
                end else begin
                    wrong_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.score_clr) score_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            letter_q  <= '0;
            prev_q    <= PREV_RST;
            timer_q   <= '0;
            dots_q    <= '0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            timeout_q <= 1'b0;
            score_q   <= '0;
        end else begin
            state_q   <= state_d;
            letter_q  <= letter_d;
            prev_q    <= prev_d;
            timer_q   <= timer_d;
            dots_q    <= dots_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
            timeout_q <= timeout_d;
            score_q   <= score_d;
        end
    end

    // disp_en and busy decode straight from the state register, so an
    // asynchronous reset drops them without waiting for a clock.
    assign bus.letter_out = letter_q;
    assign bus.disp_en    = (state_q != ST_IDLE);
    assign bus.busy       = (state_q == ST_SHOW) || (state_q == ST_CHECK);
    assign bus.correct    = correct_q;
    assign bus.wrong      = wrong_q;
    assign bus.timeout    = timeout_q;
    assign bus.score      = score_q;

endmodule

// File: tb/tb_braille_round_ctrl.sv
// tb_braille_round_ctrl
//   Directed bench for braille_round_ctrl with TIMEOUT_CYCLES=16 and
//   SCORE_W=2. Expected letters come from an independent LFSR model plus
//   the no-repeat rule; expected dots from a hand-written pattern table.
module tb_braille_round_ctrl;

    localparam int          TO   = 16;
    localparam int          SW   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    braille_round_if #(.SCORE_W(SW)) bus ();

    braille_round_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .SCORE_W        (SW),
        .LFSR_SEED      (SEED)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] pat(input logic [3:0] c);
        case (c)
            4'd0:    return 6'b000001;
            4'd1:    return 6'b000011;
            4'd2:    return 6'b001001;
            4'd3:    return 6'b011001;
            4'd4:    return 6'b010001;
            4'd5:    return 6'b001011;
            4'd6:    return 6'b011011;
            4'd7:    return 6'b010011;
            4'd8:    return 6'b001010;
            4'd9:    return 6'b011010;
            4'd10:   return 6'b000111;
            4'd11:   return 6'b010101;
            4'd12:   return 6'b001111;
            4'd13:   return 6'b001111;
            4'd14:   return 6'b100101;
            default: return 6'b111101;
        endcase
    endfunction

    // Reference LFSR: x^16+x^14+x^13+x^11, shifts every cycle.
    logic [15:0] lfsr_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= SEED;
        else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    logic [3:0] prev_m;
    logic [3:0] cur_m;
    int         sc_m;

    // Called just after a negedge; leaves the DUT in SHOW.
    task automatic do_start();
        cur_m = (lfsr_m[3:0] == prev_m) ? 4'(lfsr_m[3:0] + 4'd1) : lfsr_m[3:0];
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        prev_m = cur_m;
        chk("letter", 32'(bus.letter_out), 32'(cur_m));
        chk("disp_en_show", 32'(bus.disp_en), 32'd1);
        chk("busy_show", 32'(bus.busy), 32'd1);
        chk("flags_show", 32'({bus.correct, bus.wrong, bus.timeout}), 32'd0);
    endtask

    // Submit in SHOW; optionally assert score_clr during the CHECK cycle.
    task automatic do_submit(input logic [5:0] d, input bit clr_in_check);
        bit ok;
        bus.submit  = 1'b1;
        bus.dots_in = d;
        @(negedge clk);
        bus.submit = 1'b0;
        chk("flags_check", 32'({bus.correct, bus.wrong, bus.timeout}), 32'd0);
        chk("busy_check", 32'(bus.busy), 32'd1);
        if (clr_in_check) bus.score_clr = 1'b1;
        @(negedge clk);
        bus.score_clr = 1'b0;
        ok = (d == pat(cur_m));
        if (clr_in_check)       sc_m = 0;
        else if (ok && sc_m < 3) sc_m++;
        chk("flags_result", 32'({bus.correct, bus.wrong, bus.timeout}), ok ? 32'd4 : 32'd2);
        chk("score", 32'(bus.score), 32'(sc_m));
        chk("busy_result", 32'(bus.busy), 32'd0);
        chk("disp_en_result", 32'(bus.disp_en), 32'd1);
    endtask

    initial begin
        logic [15:0] seen;
        logic [3:0]  last_l;
        logic [5:0]  d;

        bus.start = 1'b0; bus.submit = 1'b0; bus.dots_in = '0; bus.score_clr = 1'b0;
        prev_m = 4'hF;
        sc_m   = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        repeat (10) @(negedge clk);
        chk("rst_disp_en", 32'(bus.disp_en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_score", 32'(bus.score), 32'd0);
        chk("rst_letter", 32'(bus.letter_out), 32'd0);
        chk("rst_flags", 32'({bus.correct, bus.wrong, bus.timeout}), 32'd0);

        // submit outside SHOW does nothing.
        bus.submit = 1'b1; bus.dots_in = 6'b000001;
        @(negedge clk);
        bus.submit = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_submit_busy", 32'(bus.busy), 32'd0);
        chk("idle_submit_flags", 32'({bus.correct, bus.wrong, bus.timeout}), 32'd0);
        chk("idle_submit_disp", 32'(bus.disp_en), 32'd0);

        // Correct round, then a wrong round started straight from RESULT.
        do_start();
        @(negedge clk);
        do_submit(pat(cur_m), 1'b0);
        do_start();
        do_submit(6'b000000, 1'b0);

        // Timeout exactly TO cycles after SHOW entry.
        do_start();
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge clk);
            chk("to_early", 32'(bus.timeout), 32'd0);
        end
        @(negedge clk);
        chk("to_flags", 32'({bus.correct, bus.wrong, bus.timeout}), 32'd1);
        chk("to_busy", 32'(bus.busy), 32'd0);
        chk("to_score", 32'(bus.score), 32'(sc_m));

        // submit in the very cycle the timer expires: graded, not timed out.
        do_start();
        repeat (TO - 1) @(negedge clk);
        do_submit(pat(cur_m), 1'b0);

        // Clear in RESULT, then saturation 1,2,3,3,3.
        bus.score_clr = 1'b1;
        @(negedge clk);
        bus.score_clr = 1'b0;
        sc_m = 0;
        chk("clr_score", 32'(bus.score), 32'd0);
        chk("clr_flags_held", 32'(bus.correct), 32'd1);
        for (int i = 0; i < 5; i++) begin
            do_start();
            do_submit(pat(cur_m), 1'b0);
        end
        chk("sat_final", 32'(bus.score), 32'd3);

        // Clear coincident with a correct CHECK.
        do_start();
        do_submit(pat(cur_m), 1'b1);

        // Randomised rounds.
        seen   = '0;
        last_l = bus.letter_out;
        for (int r = 0; r < 500; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_start();
            if (r > 0 || 1'b1) chk("no_repeat", 32'(bus.letter_out == last_l), 32'd0);
            last_l = bus.letter_out;
            seen[bus.letter_out] = 1'b1;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            d = ($urandom_range(0, 1) == 1) ? pat(cur_m) : 6'($urandom);
            do_submit(d, 1'b0);
        end
        chk("all_codes_seen", 32'(seen), 32'hFFFF);

        // Asynchronous reset in the middle of SHOW.
        do_start();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_disp_en", 32'(bus.disp_en), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_score", 32'(bus.score), 32'd0);
        chk("arst_letter", 32'(bus.letter_out), 32'd0);
        chk("arst_flags", 32'({bus.correct, bus.wrong, bus.timeout}), 32'd0);
        prev_m = 4'hF;
        sc_m   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        do_submit(pat(cur_m), 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
